// File: rtl/fake_slave_pipeline_param.sv
// Wishbone B4 pipelined slave model: queues requests, answers after a programmable wait,
// and backs them with a word memory; injects ERR on bad decode and periodic RTY.
module fake_slave_pipeline_param #(
    parameter int                           BUS_ADDRESS_WIDTH = 16,
    parameter int                           BUS_DATA_WIDTH    = 32,
    parameter int                           BUS_SEL_WIDTH     = 4,
    parameter logic [BUS_ADDRESS_WIDTH-1:0] BASE_ADDR         = 16'hf000,
    parameter int                           MEM_DEPTH_LOG2    = 8,
    parameter int                           QUEUE_DEPTH       = 4,
    parameter int                           WAIT_CYCLES       = 2,
    parameter int                           RTY_PERIOD        = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         gnt_wb_o,
    input  logic                         CYC_I,
    input  logic                         STB_I,
    input  logic                         WE_I,
    input  logic [BUS_ADDRESS_WIDTH-1:0] ADR_I,
    input  logic [BUS_DATA_WIDTH-1:0]    DAT_I,
    input  logic [BUS_SEL_WIDTH-1:0]     SEL_I,
    input  logic [2:0]                   CTI_I,
    output logic [BUS_DATA_WIDTH-1:0]    DAT_O,
    output logic                         ACK_O,
    output logic                         RTY_O,
    output logic                         ERR_O,
    output logic                         STALL_O
);

    localparam int WORD_SHIFT = $clog2(BUS_SEL_WIDTH);
    localparam int PTR_W      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1);
    localparam int WAIT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int RTY_W      = (RTY_PERIOD > 1) ? $clog2(RTY_PERIOD) : 1;

    localparam logic [CNT_W-1:0]  Q_FULL    = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_DONE = WAIT_W'(WAIT_CYCLES);
    localparam logic [RTY_W-1:0]  RTY_LAST  = RTY_W'((RTY_PERIOD > 0) ? RTY_PERIOD - 1 : 0);

    typedef enum logic [1:0] {
        TERM_ACK = 2'd0,
        TERM_RTY = 2'd1,
        TERM_ERR = 2'd2
    } term_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [BUS_DATA_WIDTH-1:0] mem [0:(1 << MEM_DEPTH_LOG2)-1];

    logic                      q_we   [0:QUEUE_DEPTH-1];
    logic [MEM_DEPTH_LOG2-1:0] q_word [0:QUEUE_DEPTH-1];
    logic [BUS_DATA_WIDTH-1:0] q_dat  [0:QUEUE_DEPTH-1];
    logic [BUS_SEL_WIDTH-1:0]  q_sel  [0:QUEUE_DEPTH-1];
    term_e                     q_term [0:QUEUE_DEPTH-1];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  q_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [RTY_W-1:0]  rty_cnt;

    logic [BUS_ADDRESS_WIDTH-1:0] off_p0;
    logic [BUS_ADDRESS_WIDTH:0]   word_ext_p0;
    logic [MEM_DEPTH_LOG2-1:0]    word_p0;
    logic                         dec_err_p0;
    logic                         is_rty_p0;
    term_e                        term_p0;
    logic                         vld_p0;

    logic                         head_vld;
    logic                         full;
    logic                         vld_p1;
    term_e                        head_term;
    logic                         head_we;
    logic [MEM_DEPTH_LOG2-1:0]    head_word;

    // Stage p0: request decode at accept time
    always_comb begin
        off_p0      = ADR_I - BASE_ADDR;
        word_ext_p0 = {1'b0, off_p0} >> WORD_SHIFT;
        word_p0     = MEM_DEPTH_LOG2'(word_ext_p0);
        dec_err_p0  = (ADR_I < BASE_ADDR)
                   || ((word_ext_p0 >> MEM_DEPTH_LOG2) != '0)
                   || !(CTI_I inside {3'b000, 3'b010, 3'b111});
        is_rty_p0   = (RTY_PERIOD != 0) && (rty_cnt == RTY_LAST);
        if (dec_err_p0) begin
            term_p0 = TERM_ERR;
        end else if (is_rty_p0) begin
            term_p0 = TERM_RTY;
        end else begin
            term_p0 = TERM_ACK;
        end
    end

    // Stall is taken from pre-edge occupancy, so a full queue stalls even on a popping cycle
    assign full      = (q_cnt == Q_FULL);
    assign head_vld  = (q_cnt != '0);
    assign STALL_O   = !gnt_wb_o || full;
    assign vld_p0    = CYC_I && STB_I && !STALL_O;

    // Stage p1: queue head answered once its wait has elapsed
    assign head_term = q_term[rd_ptr];
    assign head_we   = q_we[rd_ptr];
    assign head_word = q_word[rd_ptr];
    assign vld_p1    = CYC_I && head_vld && (wait_cnt == WAIT_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_wb_o <= 1'b0;
            ACK_O    <= 1'b0;
            RTY_O    <= 1'b0;
            ERR_O    <= 1'b0;
            DAT_O    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            wait_cnt <= '0;
            rty_cnt  <= '0;
        end else begin
            gnt_wb_o <= CYC_I;
            ACK_O    <= vld_p1 && (head_term == TERM_ACK);
            RTY_O    <= vld_p1 && (head_term == TERM_RTY);
            ERR_O    <= vld_p1 && (head_term == TERM_ERR);
            DAT_O    <= (vld_p1 && (head_term == TERM_ACK) && !head_we) ? mem[head_word] : '0;

            if (!CYC_I) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                q_cnt    <= '0;
                wait_cnt <= '0;
            end else begin
                if (vld_p0) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (vld_p1) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                case ({vld_p0, vld_p1})
                    2'b10:   q_cnt <= q_cnt + 1'b1;
                    2'b01:   q_cnt <= q_cnt - 1'b1;
                    default: q_cnt <= q_cnt;
                endcase
                if (vld_p1) begin
                    wait_cnt <= '0;
                end else if (head_vld) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end

            // Only requests that decode cleanly advance the retry period
            if (vld_p0 && !dec_err_p0 && (RTY_PERIOD != 0)) begin
                rty_cnt <= is_rty_p0 ? '0 : rty_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            q_we[wr_ptr]   <= WE_I;
            q_word[wr_ptr] <= word_p0;
            q_dat[wr_ptr]  <= DAT_I;
            q_sel[wr_ptr]  <= SEL_I;
            q_term[wr_ptr] <= term_p0;
        end
        if (vld_p1 && (head_term == TERM_ACK) && head_we) begin
            for (int b = 0; b < BUS_SEL_WIDTH; b++) begin
                if (q_sel[rd_ptr][b]) begin
                    mem[head_word][8*b +: 8] <= q_dat[rd_ptr][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_fake_slave_pipeline_param.sv
// Bench for fake_slave_pipeline_param: four instances with different wait/retry settings,
// driven by directed requests; a scoreboard checks every termination, its data and its cycle.
module tb_fake_slave_pipeline_param;

    localparam int N = 4;
    localparam logic [1:0] C_ACK = 2'd1;
    localparam logic [1:0] C_RTY = 2'd2;
    localparam logic [1:0] C_ERR = 2'd3;

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n [N];
    logic        gnt   [N];
    logic        cyc   [N];
    logic        stb   [N];
    logic        we    [N];
    logic [15:0] adr   [N];
    logic [31:0] dati  [N];
    logic [3:0]  sel   [N];
    logic [2:0]  cti   [N];
    logic [31:0] dato  [N];
    logic        ack   [N];
    logic        rty   [N];
    logic        err   [N];
    logic        stall [N];

    exp_t exp_q [N][$];
    int   prev_resp   [N];
    int   stall_waits [N];
    int   cyc_n  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        fake_slave_pipeline_param #(
            .BUS_ADDRESS_WIDTH(16),
            .BUS_DATA_WIDTH   (32),
            .BUS_SEL_WIDTH    (4),
            .BASE_ADDR        (16'hf000),
            .MEM_DEPTH_LOG2   (8),
            .QUEUE_DEPTH      (4),
            .WAIT_CYCLES      (g == 0 ? 2 : (g == 1 ? 0 : (g == 2 ? 3 : 1))),
            .RTY_PERIOD       (g == 3 ? 3 : 0)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n[g]),
            .gnt_wb_o(gnt[g]),
            .CYC_I   (cyc[g]),
            .STB_I   (stb[g]),
            .WE_I    (we[g]),
            .ADR_I   (adr[g]),
            .DAT_I   (dati[g]),
            .SEL_I   (sel[g]),
            .CTI_I   (cti[g]),
            .DAT_O   (dato[g]),
            .ACK_O   (ack[g]),
            .RTY_O   (rty[g]),
            .ERR_O   (err[g]),
            .STALL_O (stall[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic int wait_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    // Drive one request; record its expected termination once the slave will take it.
    task automatic req(input int k, input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] c,
                       input logic [1:0] code, input logic [31:0] rdat);
        int   tries;
        int   acc;
        int   r;
        exp_t e;
        tries = 0;
        @(negedge clk);
        stb[k] = 1'b1; we[k] = w; adr[k] = a; dati[k] = d; sel[k] = s; cti[k] = c;
        while (stall[k] && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        stall_waits[k] += tries;
        if (stall[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_accept inst %0d adr %h: still stalled after %0d cycles, required accept", k, a, tries);
        end else begin
            acc = cyc_n + 1;
            r = ((acc > prev_resp[k]) ? acc : prev_resp[k]) + 1 + wait_of(k);
            prev_resp[k] = r;
            e.code = code;
            e.dat  = rdat;
            e.cyc  = r;
            exp_q[k].push_back(e);
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        stb[k] = 1'b0;
        we[k]  = 1'b0;
    endtask

    task automatic drain(input int k);
        int t;
        t = 0;
        while (exp_q[k].size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q[k].size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain inst %0d: %0d responses outstanding, required 0", k, exp_q[k].size());
        end
    endtask

    // Monitor: every termination must match the head of its instance's expectation queue
    always @(negedge clk) begin
        int         nt;
        logic [1:0] code;
        exp_t       e;
        for (int k = 0; k < N; k++) begin
            nt = int'(ack[k]) + int'(rty[k]) + int'(err[k]);
            if (nt != 0) begin
                n_chk++;
                code = ack[k] ? C_ACK : (rty[k] ? C_RTY : C_ERR);
                if (nt > 1) begin
                    n_fail++;
                    $display("FAIL resp_onehot inst %0d: got ack %b rty %b err %b, required exactly one", k, ack[k], rty[k], err[k]);
                end else if (exp_q[k].size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected inst %0d: got code %0d at cycle %0d, required none", k, code, cyc_n);
                end else begin
                    e = exp_q[k].pop_front();
                    if (code != e.code || dato[k] != e.dat || cyc_n != e.cyc) begin
                        n_fail++;
                        $display("FAIL resp inst %0d: got code %0d dat %h cycle %0d, required code %0d dat %h cycle %0d",
                                 k, code, dato[k], cyc_n, e.code, e.dat, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = '0; dati[k] = '0; sel[k] = '0; cti[k] = '0;
            prev_resp[k] = 0; stall_waits[k] = 0;
        end

        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_gnt_%0d", k),   64'(gnt[k]), 64'd0);
            chk($sformatf("rst_term_%0d", k),  64'({ack[k], rty[k], err[k]}), 64'd0);
            chk($sformatf("rst_stall_%0d", k), 64'(stall[k]), 64'd1);
            chk($sformatf("rst_dat_%0d", k),   64'(dato[k]), 64'd0);
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b1;
            cyc[k]   = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("grant_up", 64'(gnt[0]), 64'd1);

        // Reset with requests in flight: nothing may be answered afterwards
        for (int i = 0; i < 3; i++) req(0, 1'b0, 16'hf000 + 16'(4*i), '0, 4'hf, 3'b000, C_ACK, '0);
        @(negedge clk);
        stb[0] = 1'b0;
        rst_n[0] = 1'b0;
        #1;
        chk("t1_gnt",   64'(gnt[0]), 64'd0);
        chk("t1_term",  64'({ack[0], rty[0], err[0]}), 64'd0);
        chk("t1_stall", 64'(stall[0]), 64'd1);
        chk("t1_dat",   64'(dato[0]), 64'd0);
        exp_q[0].delete();
        prev_resp[0] = 0;
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_regrant", 64'(gnt[0]), 64'd1);

        // Partial-byte write then read back
        req(0, 1'b1, 16'hf004, 32'h0000_0000, 4'hf, 3'b000, C_ACK, '0);
        idle(0); drain(0);
        req(0, 1'b1, 16'hf004, 32'hdead_beef, 4'b0011, 3'b000, C_ACK, '0);
        idle(0); drain(0);
        req(0, 1'b0, 16'hf004, '0, 4'hf, 3'b000, C_ACK, 32'h0000_beef);
        idle(0); drain(0);

        // Zero-wait streaming: one answer per cycle, never stalled
        stall_waits[1] = 0;
        for (int i = 0; i < 6; i++) req(1, 1'b1, 16'hf000 + 16'(4*i), 32'h1111_0000 + 32'(i), 4'hf, 3'b010, C_ACK, '0);
        for (int i = 0; i < 6; i++) req(1, 1'b0, 16'hf000 + 16'(4*i), '0, 4'hf, 3'b010, C_ACK, 32'h1111_0000 + 32'(i));
        idle(1);
        chk("t3_no_stall", 64'(stall_waits[1]), 64'd0);
        drain(1);

        // Backpressure: 8 held requests into a depth-4 queue with 3 wait cycles
        stall_waits[2] = 0;
        for (int i = 0; i < 8; i++) req(2, 1'b1, 16'hf200 + 16'(4*i), 32'h0000_00a0 + 32'(i), 4'hf, 3'b000, C_ACK, '0);
        idle(2);
        chk("t4_stall_wr", 64'(stall_waits[2]), 64'd10);
        drain(2);
        stall_waits[2] = 0;
        for (int i = 0; i < 8; i++) req(2, 1'b0, 16'hf200 + 16'(4*i), '0, 4'hf, 3'b000, C_ACK, 32'h0000_00a0 + 32'(i));
        idle(2);
        chk("t4_stall_rd", 64'(stall_waits[2]), 64'd10);
        drain(2);

        // Error decode and address boundaries
        req(2, 1'b0, 16'h0100, '0, 4'hf, 3'b000, C_ERR, '0);
        req(2, 1'b0, 16'hf000, '0, 4'hf, 3'b001, C_ERR, '0);
        req(2, 1'b0, 16'hf400, '0, 4'hf, 3'b000, C_ERR, '0);
        req(2, 1'b1, 16'hf200, 32'hffff_ffff, 4'hf, 3'b001, C_ERR, '0);
        req(2, 1'b1, 16'hf3fc, 32'h003f_c3fc, 4'hf, 3'b111, C_ACK, '0);
        req(2, 1'b0, 16'hf3fc, '0, 4'hf, 3'b010, C_ACK, 32'h003f_c3fc);
        req(2, 1'b0, 16'hf200, '0, 4'hf, 3'b000, C_ACK, 32'h0000_00a0);
        idle(2); drain(2);

        // Periodic retry: every third decoded request, ERR requests not counted
        req(3, 1'b1, 16'hf100, 32'h1111_1111, 4'hf, 3'b000, C_ACK, '0);
        req(3, 1'b1, 16'hf104, 32'h2222_2222, 4'hf, 3'b000, C_ACK, '0);
        req(3, 1'b1, 16'hf100, 32'h3333_3333, 4'hf, 3'b000, C_RTY, '0);
        req(3, 1'b0, 16'hf100, '0, 4'hf, 3'b000, C_ACK, 32'h1111_1111);
        req(3, 1'b1, 16'h0100, 32'h4444_4444, 4'hf, 3'b000, C_ERR, '0);
        req(3, 1'b1, 16'hf104, 32'h5555_5555, 4'hf, 3'b000, C_ACK, '0);
        req(3, 1'b1, 16'hf104, 32'h6666_6666, 4'hf, 3'b000, C_RTY, '0);
        req(3, 1'b0, 16'hf104, '0, 4'hf, 3'b000, C_ACK, 32'h5555_5555);
        req(3, 1'b0, 16'hf100, '0, 4'hf, 3'b000, C_ACK, 32'h1111_1111);
        idle(3); drain(3);

        // Abort: drop CYC with three queued
        for (int i = 0; i < 3; i++) req(0, 1'b0, 16'hf004, '0, 4'hf, 3'b000, C_ACK, 32'h0000_beef);
        @(negedge clk);
        stb[0] = 1'b0;
        cyc[0] = 1'b0;
        exp_q[0].delete();
        prev_resp[0] = 0;
        @(negedge clk);
        chk("t6_gnt_low",   64'(gnt[0]), 64'd0);
        chk("t6_stall",     64'(stall[0]), 64'd1);
        chk("t6_term_zero", 64'({ack[0], rty[0], err[0]}), 64'd0);
        repeat (4) @(negedge clk);
        cyc[0] = 1'b1;
        @(negedge clk);
        chk("t6_regrant",   64'(gnt[0]), 64'd1);
        chk("t6_q_empty",   64'(stall[0]), 64'd0);
        req(0, 1'b0, 16'hf004, '0, 4'hf, 3'b000, C_ACK, 32'h0000_beef);
        idle(0); drain(0);

        repeat (5) @(negedge clk);
        for (int k = 0; k < N; k++) chk($sformatf("final_q_%0d", k), 64'(exp_q[k].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
